// File: rtl/sb_arb_pkg.sv
// -----------------------------------------------------------------------------
// sb_arb_pkg
// Shared types, constants and helpers for the subtree round-robin arbiters.
//   arb_state_t : arbiter FSM state (IDLE / BUSY)
//   STAT_W      : width of each per-requester grant counter
//   MAX_REQ     : widest request vector rr_pick can scan
//   rr_pick()   : rotating-priority pick of the first set request bit at or
//                 after ptr, wrapping modulo n
// -----------------------------------------------------------------------------
package sb_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 32;

  // Two-window scan: the lowest set bit at index >= ptr wins. If there is none,
  // the lowest set bit overall wins, which is the wrap-around case. The
  // descending loop leaves the lowest matching index in each result. Bits at
  // or above n are ignored. The return value is meaningful only when req has
  // at least one set bit below n.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int                 n,
                                 input int                 ptr);
    int   hi;
    int   lo;
    logic hi_found;
    hi       = 0;
    lo       = 0;
    hi_found = 1'b0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n && req[i]) begin
        lo = i;
        if (i >= ptr) begin
          hi       = i;
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi : lo;
  endfunction

endpackage

// File: rtl/sb_rr_pick.sv
// -----------------------------------------------------------------------------
// sb_rr_pick
// Combinational rotating-priority encoder. Other sequencers in the tree can
// reuse it.
//   req [NUM_REQ-1:0] : request vector
//   ptr [IDX_W-1:0]   : highest-priority index (must be < NUM_REQ)
//   sel [IDX_W-1:0]   : first set request at or after ptr, wrapping
//   any               : at least one request is set (sel valid)
// -----------------------------------------------------------------------------
module sb_rr_pick
  import sb_arb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  // Zero-extend to the helper's fixed scan width.
  logic [MAX_REQ-1:0] req_ext;

  generate
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
      if (gi < NUM_REQ) begin : g_live
        assign req_ext[gi] = req[gi];
      end else begin : g_pad
        assign req_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign any = |req;
  assign sel = IDX_W'(rr_pick(req_ext, NUM_REQ, int'(ptr)));

endmodule

// File: rtl/sb_child_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sb_child_rr_arbiter
// Round-robin arbiter that shares one downstream resource among the NUM_REQ
// child instances of a subtree. A grant is held until the owner raises done,
// drops its request, or has held the grant for MAX_HOLD cycles. At least one
// IDLE cycle always separates two consecutive grants.
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   req        : request vector, bit i = requester i
//   done       : owner's transaction is complete (ignored in IDLE)
//   gnt        : registered one-hot grant
//   gnt_idx    : index of the current owner, valid while busy
//   busy       : a grant is active
//   timeout    : high during the cycle in which a grant is force-released at
//                the hold limit
//   grant_cnt  : (only with SB_ARB_STATS_EN defined) one 16-bit saturating
//                grant counter per requester, packed as slice i
// -----------------------------------------------------------------------------
module sb_child_rr_arbiter
  import sb_arb_pkg::*;
#(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               timeout
`ifdef SB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic               timeout_next;

  logic [IDX_W-1:0]   pick_sel;
  logic               pick_any;
  logic               owner_req;
  logic               hold_limit;

  sb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_reg),
    .sel (pick_sel),
    .any (pick_any)
  );

  // The owner's request bit, taken through the one-hot grant so no variable
  // index into req is needed.
  assign owner_req  = |(req & gnt_reg);
  assign hold_limit = (hold_reg == HOLD_LAST);

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    gnt_next     = gnt_reg;
    hold_next    = hold_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next = BUSY;
          idx_next   = pick_sel;
          gnt_next   = NUM_REQ'(1) << pick_sel;
          hold_next  = '0;
        end
      end
      BUSY: begin
        if (done || !owner_req || hold_limit) begin
          state_next = IDLE;
          gnt_next   = '0;
          hold_next  = '0;
          ptr_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
          // Forced release only. A done or a dropped request in the same
          // cycle is a normal release and produces no pulse.
          timeout_next = !done && owner_req;
        end else begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      gnt_reg   <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      gnt_reg   <= gnt_next;
      hold_reg  <= hold_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_idx = idx_reg;
  assign busy    = (state_reg == BUSY);
  // Flags the release cycle itself, while gnt is still high.
  assign timeout = timeout_next;

`ifdef SB_ARB_STATS_EN
  logic grant_fire;
  assign grant_fire = (state_reg == IDLE) && pick_any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      logic [STAT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (grant_fire && pick_sel == IDX_W'(gi) && cnt_reg != '1) begin
          cnt_reg <= cnt_reg + STAT_W'(1);
        end
      end
      assign grant_cnt[gi*STAT_W +: STAT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_sb_child_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sb_child_rr_arbiter
// Directed scenarios followed by randomized traffic. Every cycle, the DUT
// outputs are compared with a behavioural model of the arbitration rules.
// The model tracks the owner as an integer, the pointer, the hold count and
// the grant counts.
// -----------------------------------------------------------------------------
module tb_sb_child_rr_arbiter;

  localparam int N        = 5;
  localparam int MAX_HOLD = 16;
  localparam int IW       = $clog2(N);

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          busy;
  logic          timeout;
`ifdef SB_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  sb_child_rr_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .busy      (busy),
    .timeout   (timeout)
`ifdef SB_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state. m_owner = -1 means no grant is active.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_idx   = 0;
  int m_cnt [N];
  bit m_fresh_rst = 1'b1;
  int n_timeouts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. Drive the inputs on the falling edge, compare the
  // outputs 1 ns later, then advance the model by one rising edge.
  task automatic step(input logic r, input logic [N-1:0] q, input logic d);
    logic [N-1:0] e_gnt;
    logic         e_to;
    int           c;
    @(negedge clk);
    rst  = r;
    req  = q;
    done = d;
    #1;
    e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_to  = (m_owner >= 0) && !d && q[m_owner] && (m_hold == MAX_HOLD - 1);
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(e_to));
    if (m_owner >= 0 || m_fresh_rst) check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
`ifdef SB_ARB_STATS_EN
    for (int i = 0; i < N; i++) check($sformatf("grant_cnt[%0d]", i), 32'(grant_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
    if (e_to) n_timeouts++;

    m_fresh_rst = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_idx   = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_fresh_rst = 1'b1;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (q[c]) begin
          m_owner = c;
          m_idx   = c;
          m_hold  = 0;
          if (m_cnt[c] < 65535) m_cnt[c]++;
          $display("[TB] t=%0t grant -> requester %0d (req=%b)", $time, c, q);
          break;
        end
      end
    end else if (d || !q[m_owner] || m_hold == MAX_HOLD - 1) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_hold  = 0;
    end else begin
      m_hold++;
    end
  endtask

  initial begin
    logic [N-1:0] r_req;
    int           to_before;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // Reset and idle.
    step(1, '0, 0);
    step(1, '0, 0);
    step(0, '0, 0);
    step(0, '0, 1);   // done while idle has no effect

    // Single requester 2, done on the third busy cycle.
    step(0, 5'b00100, 0);
    step(0, 5'b00100, 0);
    step(0, 5'b00100, 0);
    step(0, 5'b00100, 1);
    step(0, 5'b00000, 0);
    check("ptr_after_single", 32'(m_ptr), 32'd3);

    // Everyone requests and done is always high: rotation with bubbles.
    for (int i = 0; i < 14; i++) step(0, 5'b11111, 1);
    step(0, '0, 0);

    // Wrap: grant 3 leaves ptr at 4, so requests on 0 and 1 give 0, then 1.
    step(0, 5'b01000, 0);
    step(0, 5'b01000, 1);
    step(0, 5'b00011, 0);
    step(0, 5'b00011, 1);
    step(0, 5'b00011, 0);
    step(0, 5'b00011, 1);
    step(0, '0, 0);

    // Timeout with a held request and no done, followed by a re-grant.
    to_before = n_timeouts;
    for (int i = 0; i < 36; i++) step(0, 5'b01000, 0);
    check("timeout_pulses", 32'(n_timeouts - to_before), 32'd2);
    step(0, '0, 0);
    step(0, '0, 0);

    // done in the final allowed cycle: normal release, so no pulse.
    to_before = n_timeouts;
    step(0, 5'b01000, 0);
    for (int i = 0; i < 20; i++) step(0, 5'b01000, (m_owner >= 0 && m_hold == MAX_HOLD - 1));
    check("timeout_suppressed", 32'(n_timeouts - to_before), 32'd0);
    step(0, '0, 0);

    // Three grants to requester 2, then a reset while requester 1 is granted.
    for (int i = 0; i < 3; i++) begin
      step(0, 5'b00100, 0);
      step(0, 5'b00100, 1);
    end
    step(0, 5'b00010, 0);
    step(0, 5'b00010, 0);
    step(1, 5'b00010, 0);
    step(0, 5'b11110, 0);   // scanning restarts at index 0, so 1 wins
    step(0, 5'b11110, 1);
    step(0, '0, 0);

    // Randomized traffic.
    r_req = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r_req = N'($urandom);
      step(($urandom_range(0, 249) == 0), r_req, ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sb_child_rr_arbiter.md
Name: sb_child_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among the NUM_REQ child instances of a generated subtree (5 per level by default).
- Each grant is held until the owner signals completion, drops its request, or hits a hold-time limit.
- Sits in the parent module between its sub-instances and the shared resource.

Parameters:
NUM_REQ, 5, number of requesters (>= 2)
MAX_HOLD, 16, maximum cycles a grant may be held (>= 2)
IDX_W, $clog2(NUM_REQ), width of the grant index (derived; do not override)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  request vector, bit i = requester i
done  input  1  owner's transaction complete; sampled only in BUSY
gnt  output  NUM_REQ  one-hot grant, registered
gnt_idx  output  IDX_W  index of current owner, valid when busy=1
busy  output  1  a grant is active
timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: gnt=0, gnt_idx=0, busy=0, timeout=0, internal ptr=0, hold_cnt=0, state=IDLE.
- States: IDLE, BUSY.
- IDLE:
  - gnt=0, busy=0.
  - If req!=0, select the first set bit scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - Next cycle: state=BUSY, gnt=onehot(sel), gnt_idx=sel, busy=1, hold_cnt=0.
  - Latency: req high at edge t gives gnt high after edge t+1.
- BUSY: hold_cnt increments each cycle. Release when any of the following holds:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) hold_cnt==MAX_HOLD-1 while neither (a) nor (b) holds. In this case only, timeout=1 for exactly the release cycle.
- Release action (next cycle):
  - state=IDLE, gnt=0, busy=0.
  - ptr = (gnt_idx+1) mod NUM_REQ, wrap from NUM_REQ-1 to 0.
  - The mandatory one-cycle IDLE bubble separates consecutive grants, including re-grant to the same requester.
- Simultaneous events:
  - done and timeout condition together: treated as a normal done release, no timeout pulse.
  - req changes from non-owners while BUSY: ignored until IDLE.
  - done in IDLE: ignored.
- hold_cnt width is $clog2(MAX_HOLD); it never exceeds MAX_HOLD-1.
- Reset mid-grant: next edge returns all state to reset values. ptr returns to 0, so fairness history is lost.
- Invariants:
  - gnt is zero or one-hot, never multi-hot.
  - busy == |gnt.
  - gnt_idx matches gnt whenever busy=1.

Optional Feature:
Macro SB_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt [NUM_REQ*16-1:0].
  - Slice i is a 16-bit saturating count of grants issued to requester i, incremented on the IDLE->BUSY edge.
  - Cleared by rst; holds at 16'hFFFF on saturation.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package sb_arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - constant STAT_W=16;
  - function rr_pick(req, ptr), returning the selected index.
- Sub-module sb_rr_pick: combinational rotating-priority encoder (req, ptr -> sel, any), reusable by other sequencers in the tree.

Test Plan:
- Reset/idle: assert rst 2 cycles, req=0 -> gnt=0, busy=0, timeout=0, gnt_idx=0.
- Single requester: req=5'b00100 at t0, done at t3 -> gnt=5'b00100 from t1 through t3 (until the t3 edge); gnt=0 at t4; ptr=3.
- Round-robin fairness: req=5'b11111 held, done pulsed each BUSY cycle -> grant order 0,1,2,3,4,0 with one IDLE cycle between grants.
- Wrap: ptr=4 (after granting 3), req=5'b00011 -> gnt_idx=0, then 1.
- Timeout: req=5'b01000 held, no done, MAX_HOLD=16 -> gnt high 16 cycles, timeout pulses on the 16th, gnt=0 next cycle; the same requester is re-granted after the bubble. Also: done on the 16th cycle -> no timeout pulse.
- Reset mid-grant and stats: rst during BUSY with gnt=5'b00010 -> gnt=0, busy=0 next cycle, next grant scans from index 0. With SB_ARB_STATS_EN defined, 3 grants to requester 2 -> grant_cnt[47:32]=3; rst clears all counts to 0.
